// File: rtl/fetch_stage.sv
// fetch_stage: owns the PC and fetches one word-aligned instruction at a time into the IF/ID slot.
// Latency: one idle cycle after reset, then a fetched word reaches the slot the cycle after its ack; zero-wait memory gives one word per cycle.
// Backpressure: a stalled slot parks one further word in a skid entry and stops requesting until decode drains the slot.
//
// Ports:
//   i_Clk, i_Rst_n                  clock, synchronous active-low reset
//   o_ImemReq, o_ImemAddr           instruction-memory request, held until i_ImemAck
//   i_ImemAck, i_ImemData           memory response, data valid with ack
//   o_Valid, i_DecodeReady          IF/ID slot handshake
//   o_Instruction, o_PC, o_PCPlus4  IF/ID slot contents
//   i_Redirect, i_RedirectPC        branch/jump redirect, flushes slot and skid
//   o_Halted                        sticky halt after a syscall reaches decode
//
// Build option: define FETCH_HALT_EN to stop fetching at a syscall word (32'h0000_000C).
// Without it the syscall is an ordinary word and o_Halted is tied low.

module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          XLEN     = 32
) (
  input  logic            i_Clk,
  input  logic            i_Rst_n,
  output logic            o_ImemReq,
  output logic [XLEN-1:0] o_ImemAddr,
  input  logic            i_ImemAck,
  input  logic [XLEN-1:0] i_ImemData,
  output logic            o_Valid,
  input  logic            i_DecodeReady,
  output logic [XLEN-1:0] o_Instruction,
  output logic [XLEN-1:0] o_PC,
  output logic [XLEN-1:0] o_PCPlus4,
  input  logic            i_Redirect,
  input  logic [XLEN-1:0] i_RedirectPC,
  output logic            o_Halted
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_SKID,
    ST_DROP,
    ST_HALT
  } state_t;

  state_t          r_state;
  logic [XLEN-1:0] r_pc;
  logic            r_req;
  logic [XLEN-1:0] r_addr;

  // IF/ID slot
  logic            r_valid;
  logic [XLEN-1:0] r_instr;
  logic [XLEN-1:0] r_slot_pc;
  logic [XLEN-1:0] r_slot_pc4;

  // one-entry skid
  logic            r_skid_vld;
  logic [XLEN-1:0] r_skid_instr;
  logic [XLEN-1:0] r_skid_pc;

  logic            w_ack;
  logic            w_take;
  logic            w_slot_free;
  logic            w_redirect;
  logic [XLEN-1:0] w_pc_plus4;
  logic [XLEN-1:0] w_redir_pc;

`ifdef FETCH_HALT_EN
  localparam logic [XLEN-1:0] SYSCALL = 32'h0000_000C;

  logic r_halted;
  logic w_ack_sys;
  logic w_skid_sys;

  assign w_ack_sys  = (i_ImemData == SYSCALL);
  assign w_skid_sys = (r_skid_instr == SYSCALL);
  // once halted, redirects are ignored until reset
  assign w_redirect = i_Redirect && !r_halted;
  assign o_Halted   = r_halted;
`else
  assign w_redirect = i_Redirect;
  assign o_Halted   = 1'b0;
`endif

  assign w_ack       = r_req && i_ImemAck;
  assign w_take      = r_valid && i_DecodeReady;
  // the slot can accept a new word if it is empty or being handed to decode now
  assign w_slot_free = !r_valid || i_DecodeReady;
  assign w_pc_plus4  = r_pc + 32'd4;
  assign w_redir_pc  = {i_RedirectPC[XLEN-1:2], 2'b00};

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) begin
      r_state      <= ST_IDLE;
      r_pc         <= RESET_PC;
      r_req        <= 1'b0;
      r_addr       <= '0;
      r_valid      <= 1'b0;
      r_instr      <= '0;
      r_slot_pc    <= '0;
      r_slot_pc4   <= '0;
      r_skid_vld   <= 1'b0;
      r_skid_instr <= '0;
      r_skid_pc    <= '0;
`ifdef FETCH_HALT_EN
      r_halted     <= 1'b0;
`endif
    end else begin
      // a slot handed to decode empties unless refilled below
      if (w_take) begin
        r_valid <= 1'b0;
      end

      if (w_redirect) begin
        r_pc       <= w_redir_pc;
        r_valid    <= 1'b0;
        r_skid_vld <= 1'b0;
        if ((r_state == ST_REQ || r_state == ST_DROP) && !i_ImemAck) begin
          // request still in flight: keep it on the bus and throw its data away
          r_state <= ST_DROP;
        end else begin
          // nothing outstanding (or it completes now and is dropped), so the
          // redirect target can go out straight away
          r_state <= ST_REQ;
          r_req   <= 1'b1;
          r_addr  <= w_redir_pc;
        end
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_state <= ST_REQ;
            r_req   <= 1'b1;
            r_addr  <= r_pc;
          end

          ST_REQ: begin
            if (w_ack) begin
              r_pc <= w_pc_plus4;
              if (w_slot_free) begin
                r_valid    <= 1'b1;
                r_instr    <= i_ImemData;
                r_slot_pc  <= r_pc;
                r_slot_pc4 <= w_pc_plus4;
                r_addr     <= w_pc_plus4;
`ifdef FETCH_HALT_EN
                if (w_ack_sys) begin
                  r_state <= ST_HALT;
                  r_req   <= 1'b0;
                end
`endif
              end else begin
                r_skid_vld   <= 1'b1;
                r_skid_instr <= i_ImemData;
                r_skid_pc    <= r_pc;
                r_state      <= ST_SKID;
                r_req        <= 1'b0;
              end
            end
          end

          ST_SKID: begin
            // the slot is always occupied here, so ready means it drains
            if (w_take) begin
              r_valid    <= 1'b1;
              r_instr    <= r_skid_instr;
              r_slot_pc  <= r_skid_pc;
              r_slot_pc4 <= r_skid_pc + 32'd4;
              r_skid_vld <= 1'b0;
              r_state    <= ST_REQ;
              r_req      <= 1'b1;
              r_addr     <= r_pc;
`ifdef FETCH_HALT_EN
              if (w_skid_sys) begin
                r_state <= ST_HALT;
                r_req   <= 1'b0;
              end
`endif
            end
          end

          ST_DROP: begin
            if (w_ack) begin
              r_state <= ST_REQ;
              r_addr  <= r_pc;
            end
          end

`ifdef FETCH_HALT_EN
          ST_HALT: begin
            // syscall sits in the slot; halt for good once decode takes it
            if (w_take) begin
              r_halted <= 1'b1;
            end
          end
`endif

          default: begin
            r_state <= ST_IDLE;
            r_req   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_ImemReq     = r_req;
  assign o_ImemAddr    = r_addr;
  assign o_Valid       = r_valid;
  assign o_Instruction = r_instr;
  assign o_PC          = r_slot_pc;
  assign o_PCPlus4     = r_slot_pc4;

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed and randomized stimulus for fetch_stage against a program-order reference.
// Latency: n/a (bench).
// Backpressure: randomized decode ready and memory ack latency.

module tb_fetch_stage;

  logic        i_Clk = 1'b0;
  logic        i_Rst_n;
  logic        o_ImemReq;
  logic [31:0] o_ImemAddr;
  logic        i_ImemAck;
  logic [31:0] i_ImemData;
  logic        o_Valid;
  logic        i_DecodeReady;
  logic [31:0] o_Instruction;
  logic [31:0] o_PC;
  logic [31:0] o_PCPlus4;
  logic        i_Redirect;
  logic [31:0] i_RedirectPC;
  logic        o_Halted;

  fetch_stage #(
    .RESET_PC(32'h0000_0000),
    .XLEN    (32)
  ) dut (
    .i_Clk        (i_Clk),
    .i_Rst_n      (i_Rst_n),
    .o_ImemReq    (o_ImemReq),
    .o_ImemAddr   (o_ImemAddr),
    .i_ImemAck    (i_ImemAck),
    .i_ImemData   (i_ImemData),
    .o_Valid      (o_Valid),
    .i_DecodeReady(i_DecodeReady),
    .o_Instruction(o_Instruction),
    .o_PC         (o_PC),
    .o_PCPlus4    (o_PCPlus4),
    .i_Redirect   (i_Redirect),
    .i_RedirectPC (i_RedirectPC),
    .o_Halted     (o_Halted)
  );

  always #5 i_Clk = ~i_Clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // memory model state
  logic [31:0] sys_addr  = 32'h0000_0001;
  int          lat_cur   = 0;
  int          fixed_lat = 0;
  bit          rand_lat  = 1'b0;
  int          waitc     = 0;
  bit          pend      = 1'b0;
  logic [31:0] pend_addr = '0;

  // program-order reference
  logic [31:0] exp_pc     = '0;
  int          delivered  = 0;
  bit          hold       = 1'b0;
  logic [31:0] hold_pc    = '0;
  logic [31:0] hold_ins   = '0;
  bit          post_redir = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == sys_addr) return 32'h0000_000C;
    return ((a * 32'h9E37_79B9) ^ 32'h5A5A_0000) | 32'h0000_1000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_cmp++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, want);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic want);
    n_cmp++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, want);
    end
  endtask

  // One clock: drive memory/decode/redirect, check invariants, advance the reference.
  task automatic tick(input bit rdy, input bit redir, input logic [31:0] rpc);
    logic        req_now;
    logic        ack_now;
    logic [31:0] addr_now;
    req_now  = o_ImemReq;
    addr_now = o_ImemAddr;
    if (pend) begin
      chk1("req_hold", o_ImemReq, 1'b1);
      chk("addr_hold", o_ImemAddr, pend_addr);
    end
    if (post_redir) chk1("valid_after_redirect", o_Valid, 1'b0);
    if (hold) begin
      chk1("slot_hold_vld", o_Valid, 1'b1);
      chk("slot_hold_pc", o_PC, hold_pc);
      chk("slot_hold_ins", o_Instruction, hold_ins);
    end
    ack_now       = req_now && (waitc >= lat_cur);
    i_ImemAck     = ack_now;
    i_ImemData    = ack_now ? mem_word(addr_now) : $urandom;
    i_DecodeReady = rdy;
    i_Redirect    = redir;
    i_RedirectPC  = rpc;
    if (o_Valid && rdy) begin
      chk("slot_pc", o_PC, exp_pc);
      chk("slot_instr", o_Instruction, mem_word(exp_pc));
      chk("slot_pc4", o_PCPlus4, exp_pc + 32'd4);
      exp_pc = exp_pc + 32'd4;
      delivered++;
    end
    hold     = o_Valid && !rdy && !redir;
    hold_pc  = o_PC;
    hold_ins = o_Instruction;
    if (redir) exp_pc = {rpc[31:2], 2'b00};
    post_redir = redir;
    @(posedge i_Clk);
    #1;
    if (req_now && ack_now) begin
      waitc   = 0;
      lat_cur = rand_lat ? int'($urandom_range(0, 3)) : fixed_lat;
      pend    = 1'b0;
    end else if (req_now) begin
      waitc++;
      pend      = 1'b1;
      pend_addr = addr_now;
    end else begin
      pend = 1'b0;
    end
    i_Redirect = 1'b0;
  endtask

  task automatic do_reset();
    i_Rst_n       = 1'b0;
    i_ImemAck     = 1'b0;
    i_ImemData    = '0;
    i_DecodeReady = 1'b0;
    i_Redirect    = 1'b0;
    i_RedirectPC  = '0;
    repeat (2) @(posedge i_Clk);
    #1;
    pend       = 1'b0;
    waitc      = 0;
    lat_cur    = fixed_lat;
    exp_pc     = 32'h0000_0000;
    hold       = 1'b0;
    post_redir = 1'b0;
    chk1("rst_req", o_ImemReq, 1'b0);
    chk("rst_addr", o_ImemAddr, 32'h0);
    chk1("rst_valid", o_Valid, 1'b0);
    chk("rst_instr", o_Instruction, 32'h0);
    chk("rst_pc", o_PC, 32'h0);
    chk("rst_pc4", o_PCPlus4, 32'h0);
    chk1("rst_halted", o_Halted, 1'b0);
    i_Rst_n = 1'b1;
  endtask

  task automatic run_until_slot(input string tag, input logic [31:0] pc, input int budget);
    int n;
    n = 0;
    while (!(o_Valid && o_PC == pc) && n < budget) begin
      tick(1'b1, 1'b0, 32'h0);
      n++;
    end
    chk1(tag, o_Valid && (o_PC == pc), 1'b1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, observed running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int found;

    // reset state and first fetch after release
    do_reset();
    tick(1'b1, 1'b0, 32'h0);
    chk1("first_req", o_ImemReq, 1'b1);
    chk("first_addr", o_ImemAddr, 32'h0);
    chk1("first_valid_low", o_Valid, 1'b0);
    tick(1'b1, 1'b0, 32'h0);
    chk1("first_valid", o_Valid, 1'b1);
    chk("first_pc", o_PC, 32'h0);
    chk("first_pc4", o_PCPlus4, 32'h4);
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 1'b0, 32'h0);
      chk1("stream_valid", o_Valid, 1'b1);
      chk("stream_pc", o_PC, 32'(4 * (i + 1)));
    end

    // three-cycle memory latency at 0x10
    chk("lat_addr", o_ImemAddr, 32'h10);
    lat_cur = 2;
    for (int i = 0; i < 2; i++) begin
      tick(1'b1, 1'b0, 32'h0);
      chk1("lat_req", o_ImemReq, 1'b1);
      chk("lat_addr_stable", o_ImemAddr, 32'h10);
      chk1("lat_valid_low", o_Valid, 1'b0);
    end
    tick(1'b1, 1'b0, 32'h0);
    chk1("lat_valid", o_Valid, 1'b1);
    chk("lat_pc", o_PC, 32'h10);
    chk("lat_next_addr", o_ImemAddr, 32'h14);

    // decode stall: 0x20 in slot, 0x24 in skid
    run_until_slot("reach_0x20", 32'h20, 20);
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 1'b0, 32'h0);
      chk("stall_pc", o_PC, 32'h20);
      chk1("stall_req", o_ImemReq, 1'b0);
    end
    tick(1'b1, 1'b0, 32'h0);
    chk1("skid_valid", o_Valid, 1'b1);
    chk("skid_pc", o_PC, 32'h24);
    tick(1'b1, 1'b0, 32'h0);

    // redirect while the request at 0x40 is unacked
    found = 0;
    for (int i = 0; i < 30; i++) begin
      if (o_ImemReq && o_ImemAddr == 32'h40) begin
        found = 1;
        break;
      end
      tick(1'b1, 1'b0, 32'h0);
    end
    chk1("reach_req_0x40", found != 0, 1'b1);
    lat_cur = 3;
    tick(1'b1, 1'b1, 32'h103);
    chk1("drop_valid", o_Valid, 1'b0);
    chk("drop_addr", o_ImemAddr, 32'h40);
    for (int i = 0; i < 2; i++) begin
      tick(1'b1, 1'b0, 32'h0);
      chk1("drop_valid_hold", o_Valid, 1'b0);
    end
    tick(1'b1, 1'b0, 32'h0);
    chk1("after_drop_valid", o_Valid, 1'b0);
    chk("after_drop_addr", o_ImemAddr, 32'h100);
    tick(1'b1, 1'b0, 32'h0);
    chk1("target_valid", o_Valid, 1'b1);
    chk("target_pc", o_PC, 32'h100);

    // PC wraparound
    tick(1'b1, 1'b1, 32'hFFFF_FFF8);
    chk("wrap_redir_addr", o_ImemAddr, 32'hFFFF_FFF8);
    run_until_slot("reach_wrap", 32'hFFFF_FFFC, 10);
    chk("wrap_pc4", o_PCPlus4, 32'h0);
    chk("wrap_next_addr", o_ImemAddr, 32'h0);
    run_until_slot("reach_after_wrap", 32'h0, 10);

    // randomized traffic
    begin
      int d0;
      d0       = delivered;
      rand_lat = 1'b1;
      for (int i = 0; i < 2000; i++) begin
        tick($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, $urandom);
      end
      chk1("random_progress", (delivered - d0) > 50, 1'b1);
      chk1("random_not_halted", o_Halted, 1'b0);
      rand_lat  = 1'b0;
      fixed_lat = 0;
    end

    // syscall at 0x8, reset abandons whatever is in flight
    sys_addr = 32'h8;
    do_reset();
    run_until_slot("reach_sys", 32'h8, 20);
    chk("sys_instr", o_Instruction, 32'h0000_000C);
`ifdef FETCH_HALT_EN
    chk1("sys_no_req", o_ImemReq, 1'b0);
    tick(1'b1, 1'b0, 32'h0);
    chk1("halted", o_Halted, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick(1'b1, 1'b0, 32'h0);
      chk1("halted_no_req", o_ImemReq, 1'b0);
      chk1("halted_sticky", o_Halted, 1'b1);
    end
    do_reset();
    run_until_slot("reach_sys2", 32'h8, 20);
    tick(1'b0, 1'b1, 32'h200);
    chk1("halt_cancel", o_Halted, 1'b0);
    chk("halt_cancel_addr", o_ImemAddr, 32'h200);
    run_until_slot("resume_target", 32'h200, 10);
    chk1("halt_cancel_final", o_Halted, 1'b0);
`else
    chk1("sys_ordinary_req", o_ImemReq, 1'b1);
    tick(1'b1, 1'b0, 32'h0);
    chk1("sys_not_halted", o_Halted, 1'b0);
    run_until_slot("sys_continue", 32'hC, 5);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction fetch stage that sits directly upstream of the register-file/decode stage. It owns the PC and issues one word-aligned request at a time to instruction memory through a req/ack handshake. Each returned word is placed in an IF/ID output slot (instruction, PC, PC+4) that decode consumes through a valid/ready handshake. A one-entry skid buffer lets fetch overlap with decode backpressure, and a redirect input services branches and jumps.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; low two bits must be 00.
XLEN, 32, width of address, data and PC paths; only 32 is supported.

Ports:
i_Clk  input  1  clock; all state updates on the rising edge.
i_Rst_n  input  1  reset, synchronous, active-low.
o_ImemReq  output  1  instruction-memory request.
o_ImemAddr  output  32  word-aligned address of the outstanding request.
i_ImemAck  input  1  memory response; i_ImemData is valid in the same cycle.
i_ImemData  input  32  fetched instruction word.
o_Valid  output  1  IF/ID slot holds a valid instruction.
i_DecodeReady  input  1  decode accepts the slot this cycle.
o_Instruction  output  32  raw instruction word for decode/register file.
o_PC  output  32  address of o_Instruction.
o_PCPlus4  output  32  o_PC + 4, modulo 2^32.
i_Redirect  input  1  branch/jump taken; flushes fetch.
i_RedirectPC  input  32  new fetch address; bits [1:0] are forced to 00.
o_Halted  output  1  fetch halted (optional feature only; otherwise tied 0).

Behaviour:
- Clock and reset: one clock (i_Clk). Reset is synchronous and active-low (i_Rst_n).
- Reset values:
  - PC = RESET_PC; state = ST_IDLE; o_ImemReq = 0; o_ImemAddr = 0.
  - o_Valid = 0; o_Instruction, o_PC, o_PCPlus4 = 0; skid empty; o_Halted = 0.
- Memory handshake:
  - A transfer completes at a rising edge where o_ImemReq && i_ImemAck.
  - o_ImemReq and o_ImemAddr stay stable until the ack.
  - At most one request is outstanding.
  - Zero-wait memory (ack in the request's first cycle) sustains one fetch per cycle.
- Decode handshake: a transfer completes at a rising edge where o_Valid && i_DecodeReady. Slot contents are stable while o_Valid && !i_DecodeReady.
- States:
  - ST_IDLE: o_ImemReq = 0. Always moves to ST_REQ next cycle (one-cycle bubble after reset).
  - ST_REQ: o_ImemReq = 1, o_ImemAddr = PC. On ack:
    - If the slot is empty or draining this cycle: load the slot {data, PC, PC+4}, PC <= PC+4, stay in ST_REQ.
    - Otherwise: write {data, PC} into the skid, PC <= PC+4, go to ST_SKID.
  - ST_SKID: o_ImemReq = 0. When the slot drains, skid -> slot, skid cleared, go to ST_REQ.
  - ST_DROP: o_ImemReq = 1 with the latched old address. Entered when a redirect arrives while a request is outstanding and unacked. On ack, the data is discarded and the state goes to ST_REQ.
- Redirect (highest priority, any state):
  - PC <= {i_RedirectPC[31:2], 2'b00}; o_Valid <= 0; skid cleared.
  - A slot handed to decode in the same cycle still counts as transferred.
  - From ST_REQ: ack in the same cycle -> data dropped, go to ST_REQ; no ack -> go to ST_DROP.
  - From ST_IDLE or ST_SKID: go to ST_REQ.
  - In ST_DROP: the PC is updated and the state stays ST_DROP.
- PC arithmetic: unsigned modulo 2^32. A fetch at 32'hFFFF_FFFC gives next PC 32'h0000_0000 and o_PCPlus4 = 0.
- Reset mid-request: the outstanding request is abandoned. Reset has priority over everything, including ack and redirect.

Optional Feature:
FETCH_HALT_EN
- Defined:
  - When the word in the slot equals 32'h0000_000C (syscall), no new request is issued. An already-outstanding request completes and its data is discarded.
  - When that syscall is transferred to decode, o_Halted <= 1 and stays sticky until reset; o_ImemReq stays 0.
  - A redirect before that transfer cancels the pending halt and fetch resumes.
- Undefined: syscall is an ordinary word; o_Halted is tied 0.

Test Plan:
- Reset release with RESET_PC = 0, zero-wait memory, i_DecodeReady = 1 -> first request at addr 0 on cycle 2. o_Valid rises on cycle 3 with o_PC = 0, o_PCPlus4 = 4. Then one instruction per cycle: PC 4, 8, 12.
- 3-cycle ack latency -> o_ImemReq/o_ImemAddr = 0x10 held stable for 3 cycles. Slot loaded once, with no duplicate or lost word.
- i_DecodeReady = 0 for 4 cycles while words at 0x20 and 0x24 return -> slot holds 0x20, skid holds 0x24, o_ImemReq = 0. On ready, 0x20 then 0x24 are delivered in order.
- i_Redirect with i_RedirectPC = 0x103 while the request at 0x40 is unacked -> state ST_DROP, the 0x40 data is discarded on its ack, the next request is at 0x100, and o_Valid = 0 until the 0x100 word arrives.
- PC = 0xFFFF_FFFC fetched -> o_PCPlus4 = 0 and the next request is at 0x0000_0000.
- FETCH_HALT_EN defined, word 0x0000_000C at 0x8 accepted by decode -> o_Halted = 1, no further o_ImemReq. Repeat with a redirect before acceptance -> o_Halted stays 0 and fetch resumes at the target.
